// File: rtl/video_timing_pkg.sv
// Shared 640x480@60 raster definitions for the pixel-stream path.
// Holds the timing constants, the per-axis phase encoding and the
// test-pattern select encodings used by the generator and the filters.
package video_timing_pkg;

  // Position counters and position buses are all this wide.
  localparam int CW = 13;

  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  // Pattern geometry: eight bars of 80 px, step edge at column 320.
  localparam int PAT_BAR_W    = 80;
  localparam int PAT_EDGE_COL = 320;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_e;

  typedef enum logic [1:0] {
    PAT_BARS    = 2'd0,
    PAT_RAMP    = 2'd1,
    PAT_CHECKER = 2'd2,
    PAT_EDGE    = 2'd3
  } pattern_e;

endpackage

// File: rtl/raster_counter.sv
// One raster axis: ACTIVE/FRONT/SYNC/BACK phase FSM with an intra-phase
// down-counter, plus an independent position up-counter.
// Ports:
//   clk, rst     - clock, synchronous active-high reset
//   i_en         - advance one position this cycle
//   o_pos        - registered position, 0..TOTAL-1
//   o_pos_nxt    - position after this cycle's edge (equals o_pos if !i_en)
//   o_phase_nxt  - phase after this cycle's edge
//   o_carry      - i_en while at the last position: the axis wraps this edge
// Reset parks the axis at its last position in BACK, so the first enabled
// step lands on position 0 in ACTIVE.
module raster_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = VGA_H_ACTIVE,
  parameter int FP     = VGA_H_FP,
  parameter int SYNC   = VGA_H_SYNC,
  parameter int BP     = VGA_H_BP
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          i_en,
  output logic [CW-1:0] o_pos,
  output logic [CW-1:0] o_pos_nxt,
  output phase_e        o_phase_nxt,
  output logic          o_carry
);

  localparam logic [CW-1:0] LAST = CW'(ACTIVE + FP + SYNC + BP - 1);

  phase_e        r_phase, w_phase_nxt;
  logic [CW-1:0] r_pos, w_pos_nxt;
  logic [CW-1:0] r_left, w_left_nxt;

  // Down-counter reload value on entering a phase.
  function automatic logic [CW-1:0] phase_last(input phase_e ph);
    unique case (ph)
      PH_ACTIVE: phase_last = CW'(ACTIVE - 1);
      PH_FRONT:  phase_last = CW'(FP - 1);
      PH_SYNC:   phase_last = CW'(SYNC - 1);
      default:   phase_last = CW'(BP - 1);
    endcase
  endfunction

  always_comb begin
    w_pos_nxt   = r_pos;
    w_phase_nxt = r_phase;
    w_left_nxt  = r_left;
    if (i_en) begin
      w_pos_nxt = (r_pos == LAST) ? '0 : r_pos + 1'b1;
      if (r_left == '0) begin
        unique case (r_phase)
          PH_ACTIVE: w_phase_nxt = PH_FRONT;
          PH_FRONT:  w_phase_nxt = PH_SYNC;
          PH_SYNC:   w_phase_nxt = PH_BACK;
          default:   w_phase_nxt = PH_ACTIVE;
        endcase
        w_left_nxt = phase_last(w_phase_nxt);
      end else begin
        w_left_nxt = r_left - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pos   <= LAST;
      r_phase <= PH_BACK;
      r_left  <= '0;
    end else begin
      r_pos   <= w_pos_nxt;
      r_phase <= w_phase_nxt;
      r_left  <= w_left_nxt;
    end
  end

  assign o_pos       = r_pos;
  assign o_pos_nxt   = w_pos_nxt;
  assign o_phase_nxt = w_phase_nxt;
  assign o_carry     = i_en && (r_pos == LAST);

endmodule

// File: rtl/video_stream_gen.sv
// Raster pixel-stream source: 640x480@60 timing (800x525 total), position
// buses and 24-bit RGB test patterns, one pixel per enabled clock.
// Ports:
//   clk, rst          - pixel clock, synchronous active-high reset
//   en                - pixel-rate enable; everything holds when low
//   pattern_sel[1:0]  - 0 bars, 1 grey ramp, 2 checkerboard, 3 step edge
//   r, g, b           - pixel colour, 0 outside active video
//   col, row          - active position, 0 outside active video
//   x_count, y_count  - full-raster position
//   de, hs_n, vs_n    - active-video flag and active-low syncs
//   frame_start       - high for pixel (0,0) until the next enabled edge
// All outputs are registers updated on the same enabled edge as the
// position, so they always describe the position shown on x/y_count.
module video_stream_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
)(
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [1:0]    pattern_sel,
  output logic [7:0]    r,
  output logic [7:0]    g,
  output logic [7:0]    b,
  output logic [CW-1:0] col,
  output logic [CW-1:0] row,
  output logic [CW-1:0] x_count,
  output logic [CW-1:0] y_count,
  output logic          de,
  output logic          hs_n,
  output logic          vs_n,
  output logic          frame_start
);

  logic [CW-1:0] w_hpos, w_hpos_nxt, w_vpos, w_vpos_nxt;
  phase_e        w_hph_nxt, w_vph_nxt;
  logic          w_hcarry, w_vcarry;

  raster_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h (
    .clk         (clk),
    .rst         (rst),
    .i_en        (en),
    .o_pos       (w_hpos),
    .o_pos_nxt   (w_hpos_nxt),
    .o_phase_nxt (w_hph_nxt),
    .o_carry     (w_hcarry)
  );

  // Vertical axis steps once per completed line.
  raster_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v (
    .clk         (clk),
    .rst         (rst),
    .i_en        (w_hcarry),
    .o_pos       (w_vpos),
    .o_pos_nxt   (w_vpos_nxt),
    .o_phase_nxt (w_vph_nxt),
    .o_carry     (w_vcarry)
  );

  // Both axes wrapping on the same edge means this edge presents (0,0).
  logic     w_de;
  pattern_e r_pat, w_pat;
  logic [2:0]  w_bar;
  logic [23:0] w_rgb;

  assign w_de  = (w_hph_nxt == PH_ACTIVE) && (w_vph_nxt == PH_ACTIVE);
  // The frame's pixel (0,0) already uses the newly selected pattern.
  assign w_pat = w_vcarry ? pattern_e'(pattern_sel) : r_pat;

  always_comb begin
    w_bar = '0;
    for (int k = 1; k < 8; k++) begin
      if (w_hpos_nxt >= CW'(k * PAT_BAR_W)) w_bar = 3'(k);
    end
  end

  always_comb begin
    w_rgb = '0;
    unique case (w_pat)
      // Bar order white..black maps each component to one inverted index bit.
      PAT_BARS:    w_rgb = {{8{~w_bar[1]}}, {8{~w_bar[2]}}, {8{~w_bar[0]}}};
      PAT_RAMP:    w_rgb = {3{w_hpos_nxt[9:2]}};
      PAT_CHECKER: w_rgb = {24{w_hpos_nxt[5] ^ w_vpos_nxt[5]}};
      default:     w_rgb = {24{w_hpos_nxt >= CW'(PAT_EDGE_COL)}};
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pat       <= pattern_e'(pattern_sel);
      r           <= '0;
      g           <= '0;
      b           <= '0;
      col         <= '0;
      row         <= '0;
      de          <= 1'b0;
      hs_n        <= 1'b1;
      vs_n        <= 1'b1;
      frame_start <= 1'b0;
    end else if (en) begin
      r_pat       <= w_pat;
      {r, g, b}   <= w_de ? w_rgb : 24'h0;
      col         <= w_de ? w_hpos_nxt : '0;
      row         <= w_de ? w_vpos_nxt : '0;
      de          <= w_de;
      hs_n        <= (w_hph_nxt != PH_SYNC);
      vs_n        <= (w_vph_nxt != PH_SYNC);
      frame_start <= w_vcarry;
    end
  end

  assign x_count = w_hpos;
  assign y_count = w_vpos;

endmodule

// File: tb/tb_video_stream_gen.sv
// Directed bench for video_stream_gen. A full-size instance covers reset,
// first pixel, line timing and mid-line reset; a reduced-raster instance
// (same pattern geometry, 416x12 total) covers whole frames, pattern
// switching and random enable gating within a short run.
module tb_video_stream_gen;

  localparam int SHA = 400, SHF = 4, SHS = 8, SHB = 4, SHT = 416;
  localparam int SVA = 6,   SVF = 2, SVS = 2, SVB = 2, SVT = 12;
  localparam int SFRAME = SHT * SVT;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic        f_rst = 1'b1, f_en = 1'b0;
  logic [1:0]  f_pat = 2'd0;
  logic [7:0]  f_r, f_g, f_b;
  logic [12:0] f_col, f_row, f_x, f_y;
  logic        f_de, f_hs, f_vs, f_fs;
  logic [79:0] f_bus;
  assign f_bus = {f_x, f_y, f_col, f_row, f_r, f_g, f_b, f_de, f_hs, f_vs, f_fs};

  logic        s_rst = 1'b1, s_en = 1'b0;
  logic [1:0]  s_pat = 2'd0;
  logic [7:0]  s_r, s_g, s_b;
  logic [12:0] s_col, s_row, s_x, s_y;
  logic        s_de, s_hs, s_vs, s_fs;
  logic [79:0] s_bus;
  assign s_bus = {s_x, s_y, s_col, s_row, s_r, s_g, s_b, s_de, s_hs, s_vs, s_fs};

  video_stream_gen u_full (
    .clk(clk), .rst(f_rst), .en(f_en), .pattern_sel(f_pat),
    .r(f_r), .g(f_g), .b(f_b), .col(f_col), .row(f_row),
    .x_count(f_x), .y_count(f_y), .de(f_de), .hs_n(f_hs), .vs_n(f_vs),
    .frame_start(f_fs)
  );

  video_stream_gen #(
    .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
    .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
  ) u_small (
    .clk(clk), .rst(s_rst), .en(s_en), .pattern_sel(s_pat),
    .r(s_r), .g(s_g), .b(s_b), .col(s_col), .row(s_row),
    .x_count(s_x), .y_count(s_y), .de(s_de), .hs_n(s_hs), .vs_n(s_vs),
    .frame_start(s_fs)
  );

  // Drive en, take one edge, sample 1 ns later.
  task automatic f_step(input logic e);
    f_en = e; @(posedge clk); #1;
  endtask
  task automatic s_step(input logic e);
    s_en = e; @(posedge clk); #1;
  endtask

  // Reset with en=1 held high: reset must win; pattern 3 latched.
  task automatic test_reset();
    f_rst = 1'b1; f_en = 1'b1; f_pat = 2'd3;
    s_rst = 1'b1; s_en = 1'b1; s_pat = 2'd0;
    @(posedge clk); #1; @(posedge clk); #1;
    n_chk++;
    if (f_bus !== {13'd799, 13'd524, 13'd0, 13'd0, 24'h0, 4'b0110}) begin
      n_fail++; $display("FAIL reset_full got=%h want=%h", f_bus,
                         {13'd799, 13'd524, 13'd0, 13'd0, 24'h0, 4'b0110});
    end
    n_chk++;
    if (s_bus !== {13'd415, 13'd11, 13'd0, 13'd0, 24'h0, 4'b0110}) begin
      n_fail++; $display("FAIL reset_small got=%h want=%h", s_bus,
                         {13'd415, 13'd11, 13'd0, 13'd0, 24'h0, 4'b0110});
    end
    s_en = 1'b0;
  endtask

  task automatic test_first_pixel();
    f_rst = 1'b0;
    f_step(1'b1);
    n_chk++;
    if (f_bus !== {13'd0, 13'd0, 13'd0, 13'd0, 24'h0, 4'b1111}) begin
      n_fail++; $display("FAIL first_pixel got=%h want=%h", f_bus,
                         {13'd0, 13'd0, 13'd0, 13'd0, 24'h0, 4'b1111});
    end
    f_step(1'b1);
    n_chk++;
    if (f_bus !== {13'd1, 13'd0, 13'd1, 13'd0, 24'h0, 4'b1110}) begin
      n_fail++; $display("FAIL second_pixel got=%h want=%h", f_bus,
                         {13'd1, 13'd0, 13'd1, 13'd0, 24'h0, 4'b1110});
    end
  endtask

  // Rest of lines 0 and 1 at full size, step-edge pattern.
  task automatic test_line_full();
    int mx = 1, my = 0, de_cnt = 2, hs_cnt = 0;
    logic e_de, e_hs;
    logic [55:0] got, exp;
    for (int i = 0; i < 1598; i++) begin
      f_step(1'b1);
      mx++;
      if (mx == 800) begin mx = 0; my++; end
      e_de = (mx < 640);
      e_hs = !(mx >= 656 && mx < 752);
      if (f_de) de_cnt++;
      if (!f_hs) hs_cnt++;
      got = {f_x, f_y, f_col, f_row, f_de, f_hs, f_vs, f_fs};
      exp = {13'(mx), 13'(my), e_de ? 13'(mx) : 13'd0, e_de ? 13'(my) : 13'd0,
             e_de, e_hs, 1'b1, 1'b0};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL line_pos x=%0d y=%0d got=%h want=%h", mx, my, got, exp);
      end
      if (!e_de || mx == 319 || mx == 320) begin
        n_chk++;
        if ({f_r, f_g, f_b} !== ((e_de && mx == 320) ? 24'hFFFFFF : 24'h0)) begin
          n_fail++; $display("FAIL line_rgb x=%0d y=%0d got=%h", mx, my, {f_r, f_g, f_b});
        end
      end
      if (mx == 799) begin
        n_chk++;
        if (de_cnt != 640 || hs_cnt != 96) begin
          n_fail++; $display("FAIL line_counts y=%0d de=%0d hs_lo=%0d want 640/96", my, de_cnt, hs_cnt);
        end
        de_cnt = 0; hs_cnt = 0;
      end
    end
  endtask

  // From (799,1) run to (300,2), reset there, then restart.
  task automatic test_reset_mid();
    for (int i = 0; i < 301; i++) f_step(1'b1);
    n_chk++;
    if ({f_x, f_y} !== {13'd300, 13'd2}) begin
      n_fail++; $display("FAIL pre_reset_pos got=%0d,%0d want 300,2", f_x, f_y);
    end
    f_rst = 1'b1; f_step(1'b1);
    n_chk++;
    if (f_bus !== {13'd799, 13'd524, 13'd0, 13'd0, 24'h0, 4'b0110}) begin
      n_fail++; $display("FAIL mid_reset got=%h", f_bus);
    end
    f_rst = 1'b0; f_step(1'b0);
    n_chk++;
    if (f_bus !== {13'd799, 13'd524, 13'd0, 13'd0, 24'h0, 4'b0110}) begin
      n_fail++; $display("FAIL post_reset_hold got=%h", f_bus);
    end
    f_step(1'b1);
    n_chk++;
    if (f_bus !== {13'd0, 13'd0, 13'd0, 13'd0, 24'h0, 4'b1111}) begin
      n_fail++; $display("FAIL restart_pixel got=%h", f_bus);
    end
  endtask

  // Four reduced frames: timing, frame period and pattern switching.
  task automatic test_frame_small();
    int mx = SHT - 1, my = SVT - 1, fr = 0, last_fs = 0, vs_cnt = 0, de_cnt = 0;
    logic e_de, e_hs, e_vs, e_fs, chk;
    logic [23:0] e_rgb;
    logic [55:0] got, exp;
    s_pat = 2'd0; s_rst = 1'b1; s_step(1'b0); s_rst = 1'b0;
    for (int cyc = 1; cyc <= 4 * SFRAME; cyc++) begin
      s_step(1'b1);
      mx++;
      if (mx == SHT) begin mx = 0; my++; end
      if (my == SVT) my = 0;
      e_fs = (mx == 0 && my == 0);
      if (e_fs) fr++;
      e_de = (mx < SHA) && (my < SVA);
      e_hs = !(mx >= SHA + SHF && mx < SHA + SHF + SHS);
      e_vs = !(my >= SVA + SVF && my < SVA + SVF + SVS);
      got = {s_x, s_y, s_col, s_row, s_de, s_hs, s_vs, s_fs};
      exp = {13'(mx), 13'(my), e_de ? 13'(mx) : 13'd0, e_de ? 13'(my) : 13'd0,
             e_de, e_hs, e_vs, e_fs};
      n_chk++;
      if (got !== exp) begin
        n_fail++; $display("FAIL frame_pos f=%0d x=%0d y=%0d got=%h want=%h", fr, mx, my, got, exp);
      end
      if (s_fs) begin
        if (last_fs != 0) begin
          n_chk++;
          if (cyc - last_fs != SFRAME) begin
            n_fail++; $display("FAIL frame_period got=%0d want=%0d", cyc - last_fs, SFRAME);
          end
        end
        last_fs = cyc;
      end
      if (!s_vs) vs_cnt++;
      if (s_de) de_cnt++;
      if (mx == SHT - 1 && my == SVT - 1) begin
        n_chk++;
        if (vs_cnt != 2 * SHT || de_cnt != SVA * SHA) begin
          n_fail++; $display("FAIL frame_counts f=%0d vs_lo=%0d de=%0d want %0d/%0d",
                             fr, vs_cnt, de_cnt, 2 * SHT, SVA * SHA);
        end
        vs_cnt = 0; de_cnt = 0;
      end
      chk = 1'b1; e_rgb = 24'h0;
      if (!e_de) e_rgb = 24'h0;
      else if (fr == 1 && mx == 85 && (my == 0 || my == 3 || my == 5)) e_rgb = 24'hFFFF00;
      else if (fr == 1 && my == 1 && (mx == 0 || mx == 79)) e_rgb = 24'hFFFFFF;
      else if (fr == 1 && my == 1 && mx == 80)  e_rgb = 24'hFFFF00;
      else if (fr == 1 && my == 1 && mx == 160) e_rgb = 24'h00FFFF;
      else if (fr == 1 && my == 1 && mx == 240) e_rgb = 24'h00FF00;
      else if (fr == 1 && my == 1 && (mx == 320 || mx == 399)) e_rgb = 24'hFF00FF;
      else if (fr == 2 && mx == 85 && (my == 0 || my == 5)) e_rgb = 24'h151515;
      else if (fr == 2 && mx == 399 && my == 0) e_rgb = 24'h636363;
      else if (fr == 3 && my == 4 && mx == 319) e_rgb = 24'h000000;
      else if (fr == 3 && my == 4 && mx == 320) e_rgb = 24'hFFFFFF;
      else if (fr == 4 && my == 0 && (mx == 31 || mx == 64)) e_rgb = 24'h000000;
      else if (fr == 4 && my == 0 && (mx == 32 || mx == 63)) e_rgb = 24'hFFFFFF;
      else chk = 1'b0;
      if (chk) begin
        n_chk++;
        if ({s_r, s_g, s_b} !== e_rgb) begin
          n_fail++; $display("FAIL frame_rgb f=%0d x=%0d y=%0d got=%h want=%h",
                             fr, mx, my, {s_r, s_g, s_b}, e_rgb);
        end
      end
      // Selector changes mid-frame; each applies only from the next frame.
      if (fr == 1 && mx == 0 && my == 3) s_pat = 2'd1;
      if (fr == 2 && mx == 0 && my == 2) s_pat = 2'd3;
      if (fr == 3 && mx == 0 && my == 1) s_pat = 2'd2;
    end
  endtask

  // Random enable gating: enabled edges follow the raster, others hold.
  task automatic test_en_toggle();
    int mx = SHT - 1, my = SVT - 1;
    logic e, e_de;
    logic [79:0] prev, exp;
    s_pat = 2'd2; s_rst = 1'b1; s_step(1'b1); s_rst = 1'b0;
    prev = s_bus;
    for (int i = 0; i < 7000; i++) begin
      e = ($urandom_range(0, 3) != 0);
      s_step(e);
      if (e) begin
        mx++;
        if (mx == SHT) begin mx = 0; my++; end
        if (my == SVT) my = 0;
        e_de = (mx < SHA) && (my < SVA);
        exp = {13'(mx), 13'(my), e_de ? 13'(mx) : 13'd0, e_de ? 13'(my) : 13'd0,
               (e_de && ((mx / 32) % 2 == 1)) ? 24'hFFFFFF : 24'h0,
               e_de, !(mx >= SHA + SHF && mx < SHA + SHF + SHS),
               !(my >= SVA + SVF && my < SVA + SVF + SVS), (mx == 0 && my == 0)};
      end else begin
        exp = prev;
      end
      n_chk++;
      if (s_bus !== exp) begin
        n_fail++; $display("FAIL en_toggle i=%0d en=%0b got=%h want=%h", i, e, s_bus, exp);
      end
      prev = s_bus;
    end
  endtask

  initial begin
    test_reset();
    test_first_pixel();
    test_line_full();
    test_reset_mid();
    f_en = 1'b0;
    test_frame_small();
    test_en_toggle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/video_stream_gen.md
# video_stream_gen

Raster pixel-stream source for the D8M loopback video path: generates 640x480@60 timing (800x525 total), the `col`/`x_count` position bus and 24-bit RGB test patterns, one pixel per enabled clock. It is the transmit end of the pixel interface consumed by `sobel_edge_det` and the other streaming filters, replacing the camera path during bring-up and regression. All outputs are registered and mutually aligned.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_FP`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BP`, 48, horizontal back porch
- `V_ACTIVE`, 480, active lines
- `V_FP`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BP`, 33, vertical back porch

- `clk` in 1: pixel-domain clock
- `rst` in 1: reset, synchronous, active-high
- `en` in 1: pixel-rate enable; position advances only on cycles with `en`=1
- `pattern_sel` in 2: 0 colour bars, 1 grey ramp, 2 checkerboard, 3 vertical step edge
- `r`, `g`, `b` out 8 each: pixel colour, 0 when `de`=0
- `col` out 13: active column 0..639, 0 when `de`=0
- `row` out 13: active line 0..479, 0 when `de`=0
- `x_count` out 13: horizontal position over the full line, 0..799
- `y_count` out 13: vertical position over the full frame, 0..524
- `de` out 1: active-video flag
- `hs_n`, `vs_n` out 1: syncs, active-low
- `frame_start` out 1: one-cycle pulse marking pixel (0,0)

## Operation
- Horizontal phases by `x_count`: ACTIVE 0..639, FRONT 640..655, SYNC 656..751, BACK 752..799; `x_count`=799 wraps to 0 and increments `y_count`.
- Vertical phases by `y_count`: ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524; 524 wraps to 0.
- Implement both as 4-state FSMs (ACTIVE/FRONT/SYNC/BACK), each with an intra-phase down-counter; `x_count`/`y_count` are separate up-counters. The FSM state must always agree with the counter ranges above.
- `de` = H ACTIVE and V ACTIVE; `hs_n`=0 in H SYNC on any line; `vs_n`=0 for every pixel of lines 490..491.
- Latch `pattern_sel` only on the pixel entering (0,0). Mid-frame changes take effect on the next frame.
- Patterns, pixel (c,l):
  - 0: eight 80-px bars, c/80 → white, yellow, cyan, green, magenta, red, blue, black (components 0x00/0xFF).
  - 1: r=g=b=c[9:2].
  - 2: white when c[5]^l[5], else black.
  - 3: 0x000000 for c<320, 0xFFFFFF for c≥320.
- Width: counters are 13-bit; compare with equality at phase ends, no subtraction.

## Timing
- Reset: internal position = (799,524), both FSMs in BACK, latched pattern = `pattern_sel` at reset. Outputs: `x_count`=799, `y_count`=524, `col`=`row`=0, rgb=0, `de`=0, `hs_n`=`vs_n`=1, `frame_start`=0.
- The first `en`=1 edge after reset presents (0,0): `de`=1, `frame_start`=1.
- Each `en`=1 edge advances one position and updates every output on that same edge. Latency from position to outputs is 0: the position and the rgb/sync derived from it are registered together.
- On `en`=0, all outputs hold. `frame_start` also holds for one cycle only if `en` was 1. It is a pulse: clear it on the next `en`=1 edge.
- `rst` overrides `en`. Reset mid-line or mid-frame returns to the reset state in one cycle, with no partial-line completion.
- Frame period: 420000 enabled cycles. Line period: 800.

## Structure
- Shared `video_timing_pkg`: the 640x480 timing constants, the phase enum (ACTIVE/FRONT/SYNC/BACK) and the pattern_sel encodings. The Sobel path and other filters reuse these.
- One sub-module, `raster_counter`: a single parameterised axis (phase FSM + position counter + wrap/carry-out), instantiated twice. The horizontal carry drives the vertical enable.
- Pattern colour logic stays inline in the top level.

## Test plan
- Reset then `en`=1 constant: cycle 1 shows `x_count`=0, `y_count`=0, `de`=1, `frame_start`=1. `frame_start` repeats exactly every 420000 cycles.
- Line check: `de` high 640 cycles per active line. `hs_n` low exactly at `x_count` 656..751 (96 cycles). `vs_n` low exactly at `y_count` 490..491 (1600 cycles).
- `pattern_sel`=3: at row 100, col 319 rgb=0x000000 and col 320 rgb=0xFFFFFF. During blanking rgb=0 and `col`=0.
- Pattern switch: change `pattern_sel` from 0 to 1 at `y_count`=200. The remaining lines stay bars (col 85 = 0xFFFF00). The next frame is ramp (col 85 → 0x151515).
- `en` toggled 1/0 randomly: output sequence equals the `en`=1 sequence with repeats. No position is skipped, and `frame_start` stays high only across held cycles.
- `rst` at `x_count`=300, `y_count`=250: next cycle shows the reset values. The first `en` after release gives (0,0) with `frame_start`=1.
